// File: rtl/mdrp_cfg_responder.sv
// mdrp_cfg_responder
// Responder end of the PLL MDRP reconfiguration port. Holds a 16-entry byte
// bank: 14 working config registers, a CTRL register (bit0 requests a
// commit) and a read-only STATUS register {5'b0, drop, busy, lock}.
// A commit copies the working registers to cfg_regs, pulses cfg_update and
// then holds lock low for SETTLE_CYCLES to emulate a PLL relock.
module mdrp_cfg_responder #(
  parameter int ADDR_W        = 4,
  parameter int SETTLE_CYCLES = 64,
  parameter int CNT_W         = 16
) (
  input  logic           mdclk,
  input  logic           rst_n,
  input  logic [1:0]     mdopc,
  input  logic           mdainc,
  input  logic [7:0]     mdwdi,
  output logic [7:0]     mdrdo,
  output logic [111:0]   cfg_regs,
  output logic           cfg_update,
  output logic           lock,
  output logic           busy
);

  localparam int NCFG = 14;
  localparam logic [ADDR_W-1:0] A_NCFG = ADDR_W'(NCFG);
  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(14);
  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(15);
  localparam logic [CNT_W-1:0]  C_SETTLE = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0]  C_ONE    = CNT_W'(1);

  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_RD = 2'b10;
  localparam logic [1:0] OP_LD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COMMIT = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [ADDR_W-1:0]      r_addr;
  logic [8*NCFG-1:0]      r_work;
  logic [8*NCFG-1:0]      r_cfg;
  logic [7:0]             r_rdo;
  logic                   r_drop;

  logic                   w_wr;
  logic                   w_rd;
  logic                   w_ld;
  logic                   w_busy;
  logic                   w_lock;
  logic                   w_cfg_hit;
  logic                   w_commit_req;
  logic [7:0]             w_rd_data;
  logic [6:0]             w_byte_base;

  assign w_wr        = (mdopc == OP_WR);
  assign w_rd        = (mdopc == OP_RD);
  assign w_ld        = (mdopc == OP_LD);
  assign w_lock      = (r_state == S_IDLE);
  assign w_busy      = ~w_lock;
  assign w_cfg_hit   = (r_addr < A_NCFG);
  assign w_byte_base = {r_addr, 3'b000};
  // Only an accepted (not busy) CTRL write with bit0 set starts a commit.
  assign w_commit_req = w_wr && w_lock && (r_addr == A_CTRL) && mdwdi[0];

  // Next-state and settle-counter logic for IDLE -> COMMIT -> SETTLE -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_commit_req) begin
          w_state_nxt = S_COMMIT;
        end
      end
      S_COMMIT: begin
        w_cnt_nxt   = C_SETTLE;
        w_state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        w_cnt_nxt = r_cnt - C_ONE;
        if (r_cnt == C_ONE) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register; reset re-enters the settle phase with a full count.
  always_ff @(posedge mdclk) begin
    if (!rst_n) begin
      r_state <= S_SETTLE;
      r_cnt   <= C_SETTLE;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Address pointer: load takes priority and ignores auto-increment.
  always_ff @(posedge mdclk) begin
    if (!rst_n) begin
      r_addr <= '0;
    end else if (w_ld) begin
      r_addr <= mdwdi[ADDR_W-1:0];
    end else if (mdainc) begin
      r_addr <= r_addr + ADDR_W'(1);
    end
  end

  // Working registers accept writes only while idle.
  always_ff @(posedge mdclk) begin
    if (!rst_n) begin
      r_work <= '0;
    end else if (w_wr && w_lock && w_cfg_hit) begin
      r_work[w_byte_base +: 8] <= mdwdi;
    end
  end

  // Read mux: CTRL always reads 0, STATUS reports the live flags.
  always_comb begin
    w_rd_data = 8'h00;
    if (w_cfg_hit) begin
      w_rd_data = r_work[w_byte_base +: 8];
    end else if (r_addr == A_STAT) begin
      w_rd_data = {5'b00000, r_drop, w_busy, w_lock};
    end
  end

  // Registered read data, held until the next read.
  always_ff @(posedge mdclk) begin
    if (!rst_n) begin
      r_rdo <= 8'h00;
    end else if (w_rd) begin
      r_rdo <= w_rd_data;
    end
  end

  // Sticky drop flag: set by a write while busy, cleared by a STATUS read.
  always_ff @(posedge mdclk) begin
    if (!rst_n) begin
      r_drop <= 1'b0;
    end else if (w_wr && w_busy) begin
      r_drop <= 1'b1;
    end else if (w_rd && (r_addr == A_STAT)) begin
      r_drop <= 1'b0;
    end
  end

  // Committed config snapshot, taken on the edge that leaves COMMIT.
  always_ff @(posedge mdclk) begin
    if (!rst_n) begin
      r_cfg <= '0;
    end else if (r_state == S_COMMIT) begin
      r_cfg <= r_work;
    end
  end

  assign mdrdo      = r_rdo;
  assign cfg_regs   = r_cfg;
  assign cfg_update = (r_state == S_COMMIT);
  assign lock       = w_lock;
  assign busy       = w_busy;

endmodule
